// File: rtl/int_pkg.sv
// Shared definitions for the interrupt sampler/controller: channel modes,
// controller FSM encoding and the default channel count.
package int_pkg;

  localparam int INT_N_CH_DEFAULT = 6;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_channel.sv
// One interrupt channel: optional 2-flop synchroniser (INT_SYNC_EN), edge/level
// detection and the pending latch, which only an ack of this channel clears.
module int_channel
  import int_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  input  logic mode_i,
  input  logic ack_i,
  output logic pending_o
);

  logic in_s;
  logic in_prev_q;
  logic pending_q;
  logic pending_d;
  logic set_evt;

`ifdef INT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = in_i;
`endif

  assign set_evt = (mode_i == MODE_EDGE) ? (in_s & ~in_prev_q) : in_s;

  // A set in the same cycle as the ack keeps the channel pending.
  assign pending_d = set_evt | (pending_q & ~ack_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      in_prev_q <= in_s;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/int_sample_ctrl.sv
// N-channel interrupt sampler/controller: per-channel pending latches, mask,
// lowest-index-wins priority and a request/ack/EOI FSM. INT_SYNC_EN adds input sync.
module int_sample_ctrl
  import int_pkg::*;
#(
  parameter int N_CH = INT_N_CH_DEFAULT,
  parameter int IDW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] int_in,
  input  logic [N_CH-1:0] int_mode,
  input  logic [N_CH-1:0] int_mask,
  input  logic            int_ack,
  input  logic            int_eoi,
  output logic            int_req,
  output logic [IDW-1:0]  int_id,
  output logic [N_CH-1:0] int_pending,
  output logic            int_active,
  output logic [1:0]      dbg_state
);

  int_state_e      state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [N_CH-1:0] clr_vec;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] id_onehot;
  logic [IDW-1:0]  prio_id;
  logic            locked_ok;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    int_channel u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_i      (int_in[g]),
      .mode_i    (int_mode[g]),
      .ack_i     (clr_vec[g]),
      .pending_o (int_pending[g])
    );
  end

  assign eligible = int_pending & int_mask;

  always_comb begin
    prio_id   = '0;
    id_onehot = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) prio_id = IDW'(i);
    end
    for (int i = 0; i < N_CH; i++) begin
      id_onehot[i] = (id_q == IDW'(i));
    end
  end

  assign locked_ok = |(eligible & id_onehot);

  // Handshake: int_req/int_id are held while in REQ; a 1-cycle int_ack there
  // takes the request, a 1-cycle int_eoi in ACTIVE ends service. Pulses in
  // any other state are ignored.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr_vec = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQ;
          id_d    = prio_id;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          clr_vec = id_onehot;
          state_d = ST_ACTIVE;
        end else if (!locked_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (int_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign int_active = (state_q == ST_ACTIVE);
  assign int_id     = id_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_int_sample_ctrl.sv
// Self-checking bench for int_sample_ctrl: directed scenarios with a queue of
// expected channel IDs popped whenever int_req rises.
module tb_int_sample_ctrl;
  import int_pkg::*;

  localparam int N_CH = 6;
  localparam int IDW  = 3;
`ifdef INT_SYNC_EN
  localparam int LAT_IN = 4;
`else
  localparam int LAT_IN = 2;
`endif

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] int_in;
  logic [N_CH-1:0] int_mode;
  logic [N_CH-1:0] int_mask;
  logic            int_ack;
  logic            int_eoi;
  logic            int_req;
  logic [IDW-1:0]  int_id;
  logic [N_CH-1:0] int_pending;
  logic            int_active;
  logic [1:0]      dbg_state;

  logic [IDW-1:0] exp_q[$];
  int checks;
  int failures;

  int_sample_ctrl #(.N_CH(N_CH), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_in      (int_in),
    .int_mode    (int_mode),
    .int_mask    (int_mask),
    .int_ack     (int_ack),
    .int_eoi     (int_eoi),
    .int_req     (int_req),
    .int_id      (int_id),
    .int_pending (int_pending),
    .int_active  (int_active),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
  endtask

  // scoreboard: wait for int_req, check latency, pop expected ID
  task automatic wait_req(input string tag, input int lat);
    int n;
    logic [IDW-1:0] exp_id;
    n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_qsz"}, (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      exp_id = exp_q.pop_front();
      check({tag, "_id"}, int_id, exp_id);
    end
  endtask

  task automatic run_edge_ch2(input string tag);
    int_in[2] = 1'b1;
    exp_q.push_back(3'd2);
    tick(LAT_IN - 1);
    check({tag, "_pend"}, int_pending, 6'h04);
    check({tag, "_noreq"}, int_req, 1'b0);
    wait_req(tag, 1);
    pulse_ack();
    check({tag, "_act"}, int_active, 1'b1);
    check({tag, "_ackreq"}, int_req, 1'b0);
    check({tag, "_ackpend"}, int_pending, 6'h00);
    pulse_eoi();
    tick(3);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
    check({tag, "_quiet"}, int_req, 1'b0);
    int_in[2] = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    int_in   = '0;
    int_mode = '0;
    int_mask = '1;
    int_ack  = 1'b0;
    int_eoi  = 1'b0;
    tick(2);
    check("rst_req", int_req, 1'b0);
    check("rst_act", int_active, 1'b0);
    check("rst_pend", int_pending, 6'h00);
    check("rst_id", int_id, 3'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: single edge channel
    run_edge_ch2("t1");

    // 2: simultaneous edges, lowest index first
    int_in[4] = 1'b1;
    int_in[1] = 1'b1;
    exp_q.push_back(3'd1);
    wait_req("t2a", LAT_IN);
    check("t2_pend", int_pending, 6'h12);
    pulse_ack();
    check("t2_actid", int_id, 3'd1);
    pulse_eoi();
    exp_q.push_back(3'd4);
    wait_req("t2b", 1);
    pulse_ack();
    pulse_eoi();
    int_in = '0;
    tick(2);
    check("t2_done", int_pending, 6'h00);

    // 3: level channel held through ack
    int_mode[0] = MODE_LEVEL;
    int_in[0]   = 1'b1;
    exp_q.push_back(3'd0);
    wait_req("t3a", LAT_IN);
    pulse_ack();
    check("t3_act", int_active, 1'b1);
    check("t3_repend", int_pending, 6'h01);
    pulse_eoi();
    exp_q.push_back(3'd0);
    wait_req("t3b", 1);
    int_in[0] = 1'b0;
    pulse_ack();
    check("t3_clr", int_pending, 6'h00);
    pulse_eoi();
    tick(3);
    check("t3_quiet", int_req, 1'b0);
    check("t3_qpend", int_pending, 6'h00);
    int_mode[0] = MODE_EDGE;

    // 4: masking
    int_mask[3] = 1'b0;
    int_in[3]   = 1'b1;
    tick(LAT_IN + 1);
    check("t4_mpend", int_pending, 6'h08);
    check("t4_mreq", int_req, 1'b0);
    int_mask[3] = 1'b1;
    exp_q.push_back(3'd3);
    wait_req("t4a", 1);
    int_mask[3] = 1'b0;
    tick();
    check("t4_drop", int_req, 1'b0);
    check("t4_idle", dbg_state, ST_IDLE);
    int_mask[3] = 1'b1;
    exp_q.push_back(3'd3);
    wait_req("t4b", 1);
    pulse_ack();
    pulse_eoi();
    int_in[3] = 1'b0;
    tick();
    check("t4_done", int_pending, 6'h00);

    // 5: new edge in the ack cycle, stray handshakes
    int_in[2] = 1'b1;
    exp_q.push_back(3'd2);
    wait_req("t5a", LAT_IN);
    int_in[2] = 1'b0;
    tick();
    int_in[2] = 1'b1;
    pulse_ack();
    check("t5_keep", int_pending, 6'h04);
    check("t5_act", int_active, 1'b1);
    pulse_eoi();
    exp_q.push_back(3'd2);
    wait_req("t5b", 1);
    pulse_eoi();
    check("t5_streoi", dbg_state, ST_REQ);
    check("t5_streq", int_req, 1'b1);
    pulse_ack();
    pulse_eoi();
    check("t5_nopend", int_pending, 6'h00);
    pulse_ack();
    check("t5_strack", dbg_state, ST_IDLE);
    check("t5_stract", int_active, 1'b0);
    int_in[2] = 1'b0;
    tick();

    // 6: asynchronous reset while ACTIVE
    int_in[5] = 1'b1;
    exp_q.push_back(3'd5);
    wait_req("t6", LAT_IN);
    pulse_ack();
    int_in[0] = 1'b1;
    tick(LAT_IN);
    check("t6_preid", int_id, 3'd5);
    check("t6_prepend", int_pending, 6'h01);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req", int_req, 1'b0);
    check("t6_act", int_active, 1'b0);
    check("t6_pend", int_pending, 6'h00);
    check("t6_id", int_id, 3'd0);
    tick();
    int_in = '0;
    rst_n  = 1'b1;
    tick(2);
    check("t6_post", int_req, 1'b0);

    // repeat the single-edge case after reset
    run_edge_ch2("t7");

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
